// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM request arbiter.
// Holds the AXI field widths, the fixed AR/AW size and burst encodings, the
// default row-field location in the address, and the arbiter state encoding.
package dram_arb_pkg;

  // AXI field widths used by the DRAM wrapper's slave address channels.
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;   // slave-side ID = {owner tag, master ID}

  // Default location of the DRAM row field inside an address.
  localparam int ROW_MSB_DEF    = 22;
  localparam int ROW_LSB_DEF    = 12;
  localparam int STARVE_MAX_DEF = 3;

  // Every burst uses 32-bit beats and incrementing addresses.
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_WAIT_R = 2'd2,
    ARB_WAIT_B = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dram_req_arbiter_if.sv
// Bundle of the requester-side and DRAM-wrapper-side signals of the arbiter.
//   req_*      : two packed requesters (bit/field i = requester i)
//   AR*/AW*    : address channels toward the wrapper's AXI slave ports
//   R*/B*      : completion monitor taps (the arbiter only observes them)
// Modports:
//   master : the arbiter (drives req_ready and the AR/AW channels)
//   slave  : the environment (requesters plus DRAM wrapper)
interface dram_req_arbiter_if;
  import dram_arb_pkg::*;

  logic [1:0]                 req_valid;
  logic [1:0]                 req_write;
  logic [2*AXI_ADDR_BITS-1:0] req_addr;
  logic [2*AXI_LEN_BITS-1:0]  req_len;
  logic [2*AXI_ID_BITS-1:0]   req_id;
  logic [1:0]                 req_ready;

  logic [AXI_IDS_BITS-1:0]  ARID_S;
  logic [AXI_ADDR_BITS-1:0] ARADDR_S;
  logic [AXI_LEN_BITS-1:0]  ARLEN_S;
  logic [2:0]               ARSIZE_S;
  logic [1:0]               ARBURST_S;
  logic                     ARVALID_S;
  logic                     ARREADY_S;

  logic [AXI_IDS_BITS-1:0]  AWID_S;
  logic [AXI_ADDR_BITS-1:0] AWADDR_S;
  logic [AXI_LEN_BITS-1:0]  AWLEN_S;
  logic [2:0]               AWSIZE_S;
  logic [1:0]               AWBURST_S;
  logic                     AWVALID_S;
  logic                     AWREADY_S;

  logic RVALID_S, RREADY_S, RLAST_S;
  logic BVALID_S, BREADY_S;

  modport master (
    input  req_valid, req_write, req_addr, req_len, req_id,
    output req_ready,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    input  RVALID_S, RREADY_S, RLAST_S,
    input  BVALID_S, BREADY_S
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, req_id,
    input  req_ready,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    output RVALID_S, RREADY_S, RLAST_S,
    output BVALID_S, BREADY_S
  );

endinterface

// File: rtl/dram_arb_pick.sv
// Arbitration policy for the two DRAM requesters (purely combinational).
// Ports:
//   valid        in  pending requests, bit i = requester i
//   row          in  row field of each request
//   last_row     in  row of the last granted burst
//   last_row_vld in  last_row holds a real row
//   owner        in  last granted requester (round-robin pointer)
//   capture      in  a grant is taken this cycle
//   starve       in  current lost-arbitration counters
//   win          out selected requester (meaningful when valid != 0)
//   starve_next  out counter values to load on the next clock
// Priority: single request > starvation limit > open-row hit > round-robin.
module dram_arb_pick #(
  parameter int ROW_W      = 11,
  parameter int STARVE_MAX = 3,
  parameter int SW         = 2
) (
  input  logic [1:0]            valid,
  input  logic [1:0][ROW_W-1:0] row,
  input  logic [ROW_W-1:0]      last_row,
  input  logic                  last_row_vld,
  input  logic                  owner,
  input  logic                  capture,
  input  logic [1:0][SW-1:0]    starve,
  output logic                  win,
  output logic [1:0][SW-1:0]    starve_next
);

  logic [1:0] sat;
  logic [1:0] hit;
  logic       rr_pick;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flags
      assign sat[gi] = (starve[gi] == SW'(STARVE_MAX));
      assign hit[gi] = last_row_vld && (row[gi] == last_row);
    end
  endgenerate

  // Round-robin favours whoever did not hold the last grant.
  assign rr_pick = ~owner;

  always_comb begin
    win = rr_pick;
    if (valid == 2'b01) begin
      win = 1'b0;
    end else if (valid == 2'b10) begin
      win = 1'b1;
    end else if (sat == 2'b11) begin
      // Both starved: neither bound can be honoured, fall back to fairness.
      win = rr_pick;
    end else if (sat[0]) begin
      win = 1'b0;
    end else if (sat[1]) begin
      win = 1'b1;
    end else if (hit == 2'b01) begin
      win = 1'b0;
    end else if (hit == 2'b10) begin
      win = 1'b1;
    end else begin
      win = rr_pick;
    end
  end

  // Winner clears; a loser that was actually waiting counts up, saturating.
  always_comb begin
    starve_next = starve;
    if (capture) begin
      for (int i = 0; i < 2; i++) begin
        if (win == 1'(i)) begin
          starve_next[i] = '0;
        end else if (valid[i] && !sat[i]) begin
          starve_next[i] = starve[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dram_req_arbiter.sv
// Two-requester transaction scheduler in front of the DRAM wrapper.
// One burst is outstanding at a time; the next grant waits for the RLAST or
// B handshake of the current burst.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset
//   bus   if   requester inputs, req_ready, AR/AW channels, R/B monitors
//   busy  out  a transaction is in flight
//   owner out  current / last granted requester
module dram_req_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ROW_MSB    = ROW_MSB_DEF,
  parameter int ROW_LSB    = ROW_LSB_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  dram_req_arbiter_if.master bus,
  output logic               busy,
  output logic               owner
);

  localparam int ROW_W = ROW_MSB - ROW_LSB + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam int OWN_W = AXI_IDS_BITS - AXI_ID_BITS;

  localparam logic [1:0] S_IDLE   = ARB_IDLE;
  localparam logic [1:0] S_ISSUE  = ARB_ISSUE;
  localparam logic [1:0] S_WAIT_R = ARB_WAIT_R;
  localparam logic [1:0] S_WAIT_B = ARB_WAIT_B;

  logic [1:0]               state_reg, state_next;
  logic                     owner_reg;
  logic                     write_reg;
  logic [AXI_ADDR_BITS-1:0] addr_reg;
  logic [AXI_LEN_BITS-1:0]  len_reg;
  logic [AXI_IDS_BITS-1:0]  id_reg;
  logic [ROW_W-1:0]         last_row_reg;
  logic                     last_row_vld_reg;
  logic [1:0][SW-1:0]       starve_reg, starve_next;

  logic [1:0][AXI_ADDR_BITS-1:0] req_addr_w;
  logic [1:0][AXI_LEN_BITS-1:0]  req_len_w;
  logic [1:0][AXI_ID_BITS-1:0]   req_id_w;
  logic [1:0][ROW_W-1:0]         req_row;

  logic win;
  logic capture;
  logic issue_hs;
  logic r_done;
  logic b_done;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_addr_w[gi] = bus.req_addr[AXI_ADDR_BITS*gi +: AXI_ADDR_BITS];
      assign req_len_w[gi]  = bus.req_len[AXI_LEN_BITS*gi +: AXI_LEN_BITS];
      assign req_id_w[gi]   = bus.req_id[AXI_ID_BITS*gi +: AXI_ID_BITS];
      assign req_row[gi]    = req_addr_w[gi][ROW_MSB:ROW_LSB];
    end
  endgenerate

  assign capture  = (state_reg == S_IDLE) && (bus.req_valid != 2'b00);
  assign issue_hs = (state_reg == S_ISSUE) &&
                    (write_reg ? bus.AWREADY_S : bus.ARREADY_S);
  // Completion taps are only honoured in the matching wait state, so stray
  // handshakes in IDLE/ISSUE (or of the wrong kind) fall through.
  assign r_done   = bus.RVALID_S && bus.RREADY_S && bus.RLAST_S;
  assign b_done   = bus.BVALID_S && bus.BREADY_S;

  dram_arb_pick #(
    .ROW_W      (ROW_W),
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .valid        (bus.req_valid),
    .row          (req_row),
    .last_row     (last_row_reg),
    .last_row_vld (last_row_vld_reg),
    .owner        (owner_reg),
    .capture      (capture),
    .starve       (starve_reg),
    .win          (win),
    .starve_next  (starve_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (capture)  state_next = S_ISSUE;
      S_ISSUE:  if (issue_hs) state_next = write_reg ? S_WAIT_B : S_WAIT_R;
      S_WAIT_R: if (r_done)   state_next = S_IDLE;
      S_WAIT_B: if (b_done)   state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      owner_reg        <= 1'b1;     // requester 0 takes the first tie
      write_reg        <= 1'b0;
      addr_reg         <= '0;
      len_reg          <= '0;
      id_reg           <= '0;
      last_row_reg     <= '0;
      last_row_vld_reg <= 1'b0;
      starve_reg       <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      if (capture) begin
        owner_reg <= win;
        write_reg <= bus.req_write[win];
        addr_reg  <= req_addr_w[win];
        len_reg   <= req_len_w[win];
        // Owner tag in the upper ID bits lets the wrapper's responses be
        // traced back to the requester.
        id_reg    <= {OWN_W'(win), req_id_w[win]};
      end
      if (issue_hs) begin
        last_row_reg     <= addr_reg[ROW_MSB:ROW_LSB];
        last_row_vld_reg <= 1'b1;
      end
    end
  end

  // Grant pulse is Mealy so the requester sees it in its request cycle.
  assign bus.req_ready = capture ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign bus.ARVALID_S = (state_reg == S_ISSUE) && !write_reg;
  assign bus.ARID_S    = id_reg;
  assign bus.ARADDR_S  = addr_reg;
  assign bus.ARLEN_S   = len_reg;
  assign bus.ARSIZE_S  = SIZE_WORD;
  assign bus.ARBURST_S = BURST_INCR;

  assign bus.AWVALID_S = (state_reg == S_ISSUE) && write_reg;
  assign bus.AWID_S    = id_reg;
  assign bus.AWADDR_S  = addr_reg;
  assign bus.AWLEN_S   = len_reg;
  assign bus.AWSIZE_S  = SIZE_WORD;
  assign bus.AWBURST_S = BURST_INCR;

  assign busy  = (state_reg != S_IDLE);
  assign owner = owner_reg;

endmodule
